fir_parallel_l3_prog: RTL

3-parallel fast FIR (FFA), the programmable-coefficient successor to the hardcoded L3 filter. It processes three input samples per clock using six polyphase sub-filters of length TAP_COUNT/3, instead of nine. Taps are runtime-loadable through a shadow bank, with an atomic commit. Data flow uses valid qualification, and the block has an optional output saturation mode. It sits between the sample-rate demux and the output serializer.

---
 rtl/fir_parallel_l3_prog_if.sv | 36 +++
 rtl/fir_parallel_l3_prog.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_parallel_l3_prog_if.sv
// Stream and coefficient-load bus for the programmable 3-parallel FFA FIR.
// The producer drives the inputs, the filter drives the outputs and coef_busy.
interface fir_parallel_l3_prog_if #(
    parameter int DATA_IN_WIDTH  = 16,
    parameter int TAP_WIDTH      = 32,
    parameter int TAP_COUNT      = 36,
    parameter int DATA_OUT_WIDTH = 64
);
    localparam int AW = $clog2(TAP_COUNT);

    logic                             valid_in;
    logic signed [DATA_IN_WIDTH-1:0]  data_in_1;
    logic signed [DATA_IN_WIDTH-1:0]  data_in_2;
    logic signed [DATA_IN_WIDTH-1:0]  data_in_3;
    logic                             coef_wr_en;
    logic [AW-1:0]                    coef_addr;
    logic signed [TAP_WIDTH-1:0]      coef_data;
    logic                             coef_commit;
    logic                             coef_busy;
    logic                             valid_out;
    logic signed [DATA_OUT_WIDTH-1:0] data_out_1;
    logic signed [DATA_OUT_WIDTH-1:0] data_out_2;
    logic signed [DATA_OUT_WIDTH-1:0] data_out_3;

    modport master (
        output valid_in, data_in_1, data_in_2, data_in_3,
        output coef_wr_en, coef_addr, coef_data, coef_commit,
        input  coef_busy, valid_out, data_out_1, data_out_2, data_out_3
    );

    modport slave (
        input  valid_in, data_in_1, data_in_2, data_in_3,
        input  coef_wr_en, coef_addr, coef_data, coef_commit,
        output coef_busy, valid_out, data_out_1, data_out_2, data_out_3
    );
endinterface

// File: rtl/fir_parallel_l3_prog.sv
// 3-parallel fast FIR (FFA) with runtime-programmable taps.
// Six polyphase sub-filters (H0, H1, H2, H0+H1, H1+H2, H0+H1+H2) of length
// TAP_COUNT/3 run on pre-added sample streams; post-adds and one-block delays
// rebuild y(3k), y(3k+1), y(3k+2). Taps are written to a shadow bank, turned
// into staged polyphase/derived taps one index per cycle, then swapped into
// the active bank on a single edge so no output block mixes two tap sets.
module fir_parallel_l3_prog #(
    parameter int DATA_IN_WIDTH  = 16,
    parameter int TAP_WIDTH      = 32,
    parameter int TAP_COUNT      = 36,
    parameter int DATA_OUT_WIDTH = 64,
    parameter int SATURATE       = 0
) (
    input logic clk,
    input logic reset,
    fir_parallel_l3_prog_if.slave bus
);
    localparam int M     = TAP_COUNT / 3;
    localparam int DL    = (M > 1) ? (M - 1) : 1;
    localparam int AW    = $clog2(TAP_COUNT);
    localparam int IW    = (M > 1) ? $clog2(M) : 1;
    localparam int XW    = DATA_IN_WIDTH + 2;
    localparam int HW    = TAP_WIDTH + 2;
    localparam int ACC_W = XW + HW + IW + 1;
    localparam int FW    = ACC_W + 3;
    localparam int EW    = ((FW > DATA_OUT_WIDTH) ? FW : DATA_OUT_WIDTH) + 1;

    localparam logic signed [EW-1:0] MAX_V =
        {{(EW - DATA_OUT_WIDTH + 1){1'b0}}, {(DATA_OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V =
        {{(EW - DATA_OUT_WIDTH + 1){1'b1}}, {(DATA_OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DERIVE = 2'd1,
        SWAP   = 2'd2
    } state_t;

    // Coefficient storage
    logic signed [TAP_WIDTH-1:0] shadow_r [TAP_COUNT];
    logic signed [HW-1:0]        stage_r  [6][M];
    logic signed [HW-1:0]        active_r [6][M];

    // Commit control
    state_t        state_r;
    state_t        state_s;
    logic [IW-1:0] idx_r;
    logic          busy_r;
    logic          derive_s;
    logic          swap_s;
    logic          wr_ok_s;

    // Datapath
    logic signed [DATA_IN_WIDTH-1:0]  in_s   [3];
    logic signed [DATA_IN_WIDTH-1:0]  dl_r   [3][DL];
    logic signed [DATA_IN_WIDTH-1:0]  win_s  [3][M];
    logic signed [XW-1:0]             pre_s  [6];
    logic signed [ACC_W-1:0]          acc_s  [6];
    logic signed [FW-1:0]             a_s    [6];
    logic signed [FW-1:0]             y_s    [3];
    logic signed [FW-1:0]             dly_next_s [2];
    logic signed [FW-1:0]             dly_r  [2];
    logic signed [DATA_OUT_WIDTH-1:0] out_r  [3];
    logic                             valid_r;

    // Reduce a full-precision result to the output width (wrap or clamp).
    function automatic logic signed [DATA_OUT_WIDTH-1:0] fit_out(input logic signed [FW-1:0] v);
        logic signed [EW-1:0] ext;
        ext = EW'(v);
        if ((SATURATE != 32'sd0) && (ext > MAX_V)) begin
            fit_out = MAX_V[DATA_OUT_WIDTH-1:0];
        end else if ((SATURATE != 32'sd0) && (ext < MIN_V)) begin
            fit_out = MIN_V[DATA_OUT_WIDTH-1:0];
        end else begin
            fit_out = ext[DATA_OUT_WIDTH-1:0];
        end
    endfunction

    assign in_s[0] = bus.data_in_1;
    assign in_s[1] = bus.data_in_2;
    assign in_s[2] = bus.data_in_3;

    assign bus.data_out_1 = out_r[0];
    assign bus.data_out_2 = out_r[1];
    assign bus.data_out_3 = out_r[2];
    assign bus.valid_out  = valid_r;
    assign bus.coef_busy  = busy_r;

    // Shadow writes are accepted only when idle and in range.
    assign wr_ok_s = bus.coef_wr_en && !busy_r &&
                     ({1'b0, bus.coef_addr} < (AW + 1)'(TAP_COUNT));

    // Commit FSM next-state and phase strobes.
    always_comb begin
        state_s  = state_r;
        derive_s = 1'b0;
        swap_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.coef_commit) begin
                    state_s = DERIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            DERIVE: begin
                derive_s = 1'b1;
                if (idx_r == IW'(M - 1)) begin
                    state_s = SWAP;
                end else begin
                    state_s = DERIVE;
                end
            end
            SWAP: begin
                swap_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Commit FSM state, derive index and registered busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            if (state_r == IDLE) begin
                idx_r <= '0;
            end else if (derive_s) begin
                idx_r <= idx_r + IW'(1);
            end
        end
    end

    // Shadow tap bank, written by the host.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAP_COUNT; i++) begin
                shadow_r[i] <= '0;
            end
        end else if (wr_ok_s) begin
            for (int i = 0; i < TAP_COUNT; i++) begin
                if (bus.coef_addr == AW'(i)) begin
                    shadow_r[i] <= bus.coef_data;
                end
            end
        end
    end

    // Staging banks: one polyphase index of all six sub-filters per DERIVE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 6; s++) begin
                for (int m = 0; m < M; m++) begin
                    stage_r[s][m] <= '0;
                end
            end
        end else begin
            for (int m = 0; m < M; m++) begin
                if (derive_s && (idx_r == IW'(m))) begin
                    stage_r[0][m] <= HW'(shadow_r[3*m]);
                    stage_r[1][m] <= HW'(shadow_r[3*m+1]);
                    stage_r[2][m] <= HW'(shadow_r[3*m+2]);
                    stage_r[3][m] <= HW'(shadow_r[3*m]) + HW'(shadow_r[3*m+1]);
                    stage_r[4][m] <= HW'(shadow_r[3*m+1]) + HW'(shadow_r[3*m+2]);
                    stage_r[5][m] <= HW'(shadow_r[3*m]) + HW'(shadow_r[3*m+1])
                                   + HW'(shadow_r[3*m+2]);
                end
            end
        end
    end

    // Active banks: all six replaced together on the SWAP edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 6; s++) begin
                for (int m = 0; m < M; m++) begin
                    active_r[s][m] <= '0;
                end
            end
        end else if (swap_s) begin
            active_r <= stage_r;
        end
    end

    // Per-lane sample window: current block followed by the M-1 previous blocks.
    always_comb begin
        for (int l = 0; l < 3; l++) begin
            for (int m = 0; m < M; m++) begin
                win_s[l][m] = '0;
            end
            win_s[l][0] = in_s[l];
            for (int m = 1; m < M; m++) begin
                win_s[l][m] = dl_r[l][m-1];
            end
        end
    end

    // Pre-adds and the six sub-filter multiply-accumulates.
    always_comb begin
        for (int s = 0; s < 6; s++) begin
            acc_s[s] = '0;
            pre_s[s] = '0;
        end
        for (int m = 0; m < M; m++) begin
            pre_s[0] = XW'(win_s[0][m]);
            pre_s[1] = XW'(win_s[1][m]);
            pre_s[2] = XW'(win_s[2][m]);
            pre_s[3] = XW'(win_s[0][m]) + XW'(win_s[1][m]);
            pre_s[4] = XW'(win_s[1][m]) + XW'(win_s[2][m]);
            pre_s[5] = XW'(win_s[0][m]) + XW'(win_s[1][m]) + XW'(win_s[2][m]);
            for (int s = 0; s < 6; s++) begin
                acc_s[s] = acc_s[s] + ACC_W'(pre_s[s]) * ACC_W'(active_r[s][m]);
            end
        end
    end

    // FFA post-add: current-block terms plus terms delayed by one block.
    always_comb begin
        for (int s = 0; s < 6; s++) begin
            a_s[s] = FW'(acc_s[s]);
        end
        y_s[0]        = a_s[0] + dly_r[0];
        y_s[1]        = a_s[3] - a_s[0] - a_s[1] + dly_r[1];
        y_s[2]        = a_s[5] - a_s[3] - a_s[4] + a_s[1] + a_s[1];
        dly_next_s[0] = a_s[4] - a_s[1] - a_s[2];
        dly_next_s[1] = a_s[2];
    end

    // Filter state and outputs advance only on accepted blocks; outputs hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < 3; l++) begin
                for (int j = 0; j < DL; j++) begin
                    dl_r[l][j] <= '0;
                end
                out_r[l] <= '0;
            end
            dly_r[0] <= '0;
            dly_r[1] <= '0;
            valid_r  <= 1'b0;
        end else if (bus.valid_in) begin
            for (int l = 0; l < 3; l++) begin
                dl_r[l][0] <= in_s[l];
                for (int j = 1; j < DL; j++) begin
                    dl_r[l][j] <= dl_r[l][j-1];
                end
                out_r[l] <= fit_out(y_s[l]);
            end
            dly_r[0] <= dly_next_s[0];
            dly_r[1] <= dly_next_s[1];
            valid_r  <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end
endmodule
